// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding HI/LO with a busy countdown.
// Define MDU_MADD_EN to enable madd/maddu/msub accumulate ops.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        start,
  output logic        stall_md,
  output logic [31:0] mdu_out
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;

  logic [31:0]   hi, lo;
  logic [31:0]   p_hi, p_lo;
  logic          p_skip;
  logic [CW-1:0] cnt;

  logic          is_mul, is_div, is_mac;
  logic [63:0]   sa, sb, ua, ub;
  logic [63:0]   prod_s, prod_u, res;
  logic [31:0]   b_nz, a_mag, b_mag;
  logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic          div_zero;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mac = (op == OP_MADD) || (op == OP_MADDU)
          || (op == OP_MSUB);
`else
    is_mac = 1'b0;
`endif
    start    = (is_mul | is_div | is_mac) & ~req & ~busy;
    stall_md = busy | start;
  end

  // Signed divide goes through magnitudes so INT_MIN/-1 wraps cleanly.
  always_comb begin
    sa     = {{32{A[31]}}, A};
    sb     = {{32{B[31]}}, B};
    ua     = {32'b0, A};
    ub     = {32'b0, B};
    prod_s = sa * sb;
    prod_u = ua * ub;
    b_nz   = (B == 32'b0) ? 32'd1 : B;
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    q_s    = (A[31] ^ b_nz[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = A / b_nz;
    r_u    = A % b_nz;
    div_zero = is_div & (B == 32'b0);
  end

  always_comb begin
    res = prod_s;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {r_s, q_s};
      OP_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
`endif
      default:  res = prod_s;
    endcase
  end

  always_comb begin
    mdu_out = 32'b0;
    if (op == OP_MFHI) mdu_out = hi;
    else if (op == OP_MFLO) mdu_out = lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= 32'b0;
      lo     <= 32'b0;
      p_hi   <= 32'b0;
      p_lo   <= 32'b0;
      p_skip <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (!p_skip) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end
    end else if (start) begin
      p_hi   <= res[63:32];
      p_lo   <= res[31:0];
      p_skip <= div_zero;
      cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy   <= 1'b1;
    end else if (!req) begin
      if (op == OP_MTHI) hi <= A;
      if (op == OP_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and random checks of e_mdu against a 64-bit HI/LO model.
// Covers latency, divide-by-zero, req masking, async reset and MDU_MADD_EN ops.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, start, stall_md;
  logic [31:0] mdu_out;

  logic [31:0] m_hi, m_lo;
  int          n_pass = 0;
  int          n_tot  = 0;

  e_mdu #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .A       (a),
    .B       (b),
    .req     (req),
    .busy    (busy),
    .start   (start),
    .stall_md(stall_md),
    .mdu_out (mdu_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic start_class(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return o inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB};
`else
    return o inside {MULT, MULTU, DIV, DIVU};
`endif
  endfunction

  // Reference arithmetic from the architectural definition.
  function automatic void model_calc(input logic [3:0] o,
                                     input logic [31:0] av,
                                     input logic [31:0] bv,
                                     output logic [63:0] r,
                                     output logic wr);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa  = $signed(av);
    sb  = $signed(bv);
    ua  = av;
    ub  = bv;
    acc = {m_hi, m_lo};
    wr  = 1'b1;
    r   = acc;
    case (o)
      MULT:  r = sa * sb;
      MULTU: r = ua * ub;
      DIV: begin
        if (bv == 0) wr = 1'b0;
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (bv == 0) wr = 1'b0;
        else begin
          q  = longint'(ua / ub);
          rm = longint'(ua % ub);
          r  = {rm[31:0], q[31:0]};
        end
      end
      MADD:  r = acc + sa * sb;
      MADDU: r = acc + ua * ub;
      MSUB:  r = acc - sa * sb;
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic rd_chk(input string tag);
    @(negedge clk);
    req = 1'b0;
    op  = MFHI;
    #1 chk({tag, "_hi"}, mdu_out, m_hi);
    chk({tag, "_busy"}, busy, 1'b0);
    op = MFLO;
    #1 chk({tag, "_lo"}, mdu_out, m_lo);
    op = NONE;
    #1 chk({tag, "_none"}, mdu_out, 32'b0);
  endtask

  task automatic rd_exp(input string tag,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    @(negedge clk);
    req = 1'b0;
    op  = MFHI;
    #1 chk({tag, "_hi"}, mdu_out, eh);
    op = MFLO;
    #1 chk({tag, "_lo"}, mdu_out, el);
    op = NONE;
  endtask

  task automatic do_op(input logic [3:0] o,
                       input logic [31:0] av,
                       input logic [31:0] bv,
                       input logic r);
    logic        exp_st, wr;
    logic [63:0] res;
    int          k;
    @(negedge clk);
    op  = o;
    a   = av;
    b   = bv;
    req = r;
    #1;
    exp_st = start_class(o) && !r;
    chk("start", start, exp_st);
    chk("stall_md", stall_md, exp_st);
    if (o == MFHI || o == MFLO) chk("rd_op", mdu_out, (o == MFHI) ? m_hi : m_lo);
    model_calc(o, av, bv, res, wr);
    k = (o == DIV || o == DIVU) ? DC : MC;
    if (exp_st) begin
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        req = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom;
        op  = (i == 1) ? MTHI : MFLO;
        #1;
        chk("busy_on", busy, 1'b1);
        chk("stall_on", stall_md, 1'b1);
        chk("start_busy", start, 1'b0);
        if (i != 1) chk("old_lo", mdu_out, m_lo);
      end
      if (wr) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
    end
    rd_chk("post");
  endtask

  task automatic do_mt(input logic [3:0] o,
                       input logic [31:0] av,
                       input logic r);
    @(negedge clk);
    op  = o;
    a   = av;
    b   = $urandom;
    req = r;
    #1 chk("mt_start", start, 1'b0);
    if (!r) begin
      if (o == MTHI) m_hi = av;
      else m_lo = av;
    end
    rd_chk("mt");
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rr;
    reset = 1'b1;
    op    = NONE;
    a     = 32'b0;
    b     = 32'b0;
    req   = 1'b0;
    m_hi  = 32'b0;
    m_lo  = 32'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_stall", stall_md, 1'b0);
    op = MFHI;
    #1 chk("rst_hi", mdu_out, 32'b0);
    op = MFLO;
    #1 chk("rst_lo", mdu_out, 32'b0);
    op = NONE;
    @(negedge clk);
    reset = 1'b0;

    do_op(MULT, 32'hFFFFFFFF, 32'h2, 1'b0);
    rd_exp("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op(MULTU, 32'hFFFFFFFF, 32'h2, 1'b0);
    rd_exp("multu", 32'h1, 32'hFFFFFFFE);
    do_op(DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    rd_exp("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(DIVU, 32'h7, 32'h2, 1'b0);
    rd_exp("divu", 32'h1, 32'h3);
    do_op(DIV, 32'h7, 32'hFFFFFFFE, 1'b0);
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    do_mt(MTHI, 32'h11, 1'b0);
    do_mt(MTLO, 32'h22, 1'b0);
    do_op(DIVU, 32'h7, 32'h0, 1'b0);
    rd_exp("div0", 32'h11, 32'h22);
    do_op(DIV, 32'h5, 32'h0, 1'b0);

    do_op(MULT, 32'h3, 32'h5, 1'b1);
    do_mt(MTLO, 32'h55, 1'b1);
    rd_exp("req", 32'h11, 32'h22);
    do_op(MFLO, 32'h0, 32'h0, 1'b0);

    do_mt(MTHI, 32'hA5A5A5A5, 1'b0);
    do_mt(MTLO, 32'h5A5A5A5A, 1'b0);
    @(negedge clk);
    op  = DIV;
    a   = 32'd100;
    b   = 32'd7;
    req = 1'b0;
    @(negedge clk);
    op = NONE;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_stall", stall_md, 1'b0);
    op = MFHI;
    #1 chk("rst_mid_hi", mdu_out, 32'b0);
    op = MFLO;
    #1 chk("rst_mid_lo", mdu_out, 32'b0);
    op   = NONE;
    m_hi = 32'b0;
    m_lo = 32'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    rd_chk("rst_after");

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'b0 : $urandom;
      rr = ($urandom_range(0, 3) == 0);
      if (ro == MTHI || ro == MTLO) do_mt(ro, ra, rr);
      else do_op(ro, ra, rb, rr);
    end

`ifdef MDU_MADD_EN
    do_mt(MTHI, 32'h0, 1'b0);
    do_mt(MTLO, 32'hFFFFFFFF, 1'b0);
    do_op(MADDU, 32'h1, 32'h1, 1'b0);
    rd_exp("maddu", 32'h1, 32'h0);
    do_op(MSUB, 32'h2, 32'h1, 1'b0);
    rd_exp("msub", 32'h0, 32'hFFFFFFFE);
    for (int i = 0; i < 8; i++) begin
      ro = 4'($urandom_range(9, 11));
      do_op(ro, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
`else
    do_mt(MTHI, 32'h1234, 1'b0);
    do_op(MADD, 32'h3, 32'h4, 1'b0);
    do_op(MADDU, 32'h3, 32'h4, 1'b0);
    do_op(MSUB, 32'h3, 32'h4, 1'b0);
    rd_exp("no_madd", 32'h1234, m_lo);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the E-stage ALU.
- Its read result (mdu_out) and the ALU result Y feed the same E-stage result mux. That mux drives the E/M pipeline register.
- Holds the architectural HI/LO registers and models the multi-cycle MIPS mult/div latency with a busy counter.
- Raises a stall request so the D-stage hazard unit holds later mult/div/mf/mt instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- op  in  4  E-stage MDU operation: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 mfhi, 1000 mflo, 1001 madd, 1010 maddu, 1011 msub (1001-1011 only with the optional feature).
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- req  in  1  exception/interrupt request for the instruction in E; suppresses any new start or HI/LO write this cycle.
- busy  out  1  operation in progress.
- start  out  1  combinational; a start-class op is accepted this cycle.
- stall_md  out  1  busy | start; consumed by the hazard unit.
- mdu_out  out  32  HI when op=mfhi, LO when op=mflo, else 0; combinational from the current HI/LO.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending result=0. All outputs are therefore 0 until the first accepted op.
- Start acceptance: start = (op is mult/multu/div/divu[/madd family]) & !req & !busy.
- Start-class op while busy: ignored. The hazard unit guarantees this does not occur.
- Start-class op while req=1: ignored; busy stays 0.
- On the accepted edge:
  - compute the full result from A/B;
  - latch it into internal pending HI/LO;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0): accepted and busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- Countdown: counter decrements each cycle while busy. On the edge where counter goes 1->0: busy clears and pending values are committed to HI/LO.
- Latency: a start at edge N gives busy=1 for exactly N+1..N+k and updated HI/LO visible from N+k, where k = MULT_CYCLES or DIV_CYCLES.
- mthi/mtlo: write A to HI/LO at the clock edge when !busy & !req. If busy, the write is ignored (the hazard unit stalls these).
- mfhi/mflo: pure reads; mdu_out shows the committed HI/LO, never the pending values.
- Reset asserted mid-operation: everything clears immediately (asynchronous); the pending result is discarded.
- req is ignored once an operation has started: the in-flight operation completes and commits.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 1001/1010/1011 are start-class with MULT_CYCLES latency.
  - madd: {HI,LO} += signed A*B.
  - maddu: {HI,LO} += unsigned A*B.
  - msub: {HI,LO} -= signed A*B.
  - All use HI/LO as sampled at the accepted edge; the 64-bit sum wraps modulo 2^64.
- Undefined: ops 1001-1011 behave as 0000 (no start, no write, mdu_out=0).

Test Plan:
1. Signed vs unsigned multiply:
   - mult A=FFFFFFFF, B=00000002 -> busy high 5 cycles; then HI=FFFFFFFF, LO=FFFFFFFE; mfhi gives FFFFFFFF.
   - multu with the same operands -> HI=00000001, LO=FFFFFFFE.
2. Signed and unsigned divide:
   - div A=FFFFFFF9 (-7), B=00000002 -> busy 10 cycles; LO=FFFFFFFD, HI=FFFFFFFF.
   - divu A=7, B=2 -> LO=3, HI=1.
3. Divide by zero: mthi 0x11 and mtlo 0x22, then divu A=7, B=0 -> busy 10 cycles; HI=00000011, LO=00000022 unchanged.
4. req handling:
   - mult with req=1 -> start=0, busy=0, HI/LO unchanged.
   - mtlo A=0x55 with req=1 -> LO unchanged.
5. Reset and stall timing:
   - Start div, assert reset on cycle 4 -> busy=0, HI=LO=0 immediately; no later commit.
   - During busy, stall_md=1 every cycle and mflo returns the old LO.
6. Optional feature (MDU_MADD_EN defined): HI=0, LO=FFFFFFFF, then maddu A=1, B=1 -> HI=00000001, LO=00000000 after 5 cycles.
